// File: rtl/lcd_spi_sequencer.sv
// Shares one byte-level SPI engine between CPU single-byte writes and a hardware
// rectangle-fill burst (RAMWR followed by N RGB565 pixels), one byte at a time.
module lcd_spi_sequencer #(
  parameter int unsigned PIX_W     = 17,
  parameter logic [7:0]  RAMWR_CMD = 8'h2C
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_req_in,
  input  logic             cpu_dc_in,
  input  logic [7:0]       cpu_data_in,
  output logic             cpu_ack_out,
  input  logic             fill_start_in,
  input  logic [15:0]      fill_color_in,
  input  logic [PIX_W-1:0] fill_count_in,
  output logic             fill_busy_out,
  output logic             fill_done_out,
  output logic             byte_start_out,
  output logic [7:0]       byte_data_out,
  output logic             byte_dc_out,
  input  logic             byte_busy_in,
  input  logic             byte_done_in
);

  typedef enum logic [2:0] {
    StIdle, StCpuIssue, StCpuWait, StFCmd, StFHi, StFLo, StFEnd
  } state_e;

  state_e           state_q, state_d;
  logic             wait_q, wait_d;
  logic             pending_q, pending_d;
  logic [15:0]      color_q, color_d;
  logic [PIX_W-1:0] count_q, count_d;
  logic [7:0]       data_q, data_d;
  logic             dc_q, dc_d;
  logic             ack_q, ack_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wait_q    <= 1'b0;
      pending_q <= 1'b0;
      color_q   <= '0;
      count_q   <= '0;
      data_q    <= '0;
      dc_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      color_q   <= color_d;
      count_q   <= count_d;
      data_q    <= data_d;
      dc_q      <= dc_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pending_d      = pending_q;
    color_d        = color_q;
    count_d        = count_q;
    data_d         = data_q;
    dc_d           = dc_q;
    ack_d          = 1'b0;
    byte_start_out = 1'b0;
    fill_done_out  = 1'b0;

    if (fill_start_in && !pending_q) begin
      pending_d = 1'b1;
      color_d   = fill_color_in;
      count_d   = fill_count_in;
    end

    unique case (state_q)
      StIdle: begin
        // ack_q blocks re-accepting the request the CPU is still holding while it sees the ack
        if (cpu_req_in && !ack_q && !byte_busy_in) begin
          state_d = StCpuIssue;
          data_d  = cpu_data_in;
          dc_d    = cpu_dc_in;
        end else if (pending_q && !cpu_req_in && !byte_busy_in) begin
          state_d = StFCmd;
          wait_d  = 1'b0;
          data_d  = RAMWR_CMD;
          dc_d    = 1'b0;
        end
      end
      StCpuIssue: begin
        if (!byte_busy_in) begin
          byte_start_out = 1'b1;
          state_d        = StCpuWait;
        end
      end
      StCpuWait: begin
        if (byte_done_in) begin
          state_d = StIdle;
          ack_d   = 1'b1;
        end
      end
      StFCmd, StFHi, StFLo: begin
        if (!wait_q) begin
          if (!byte_busy_in) begin
            byte_start_out = 1'b1;
            wait_d         = 1'b1;
          end
        end else if (byte_done_in) begin
          wait_d = 1'b0;
          dc_d   = 1'b1;
          if (state_q == StFCmd) begin
            state_d = (count_q == '0) ? StFEnd : StFHi;
            data_d  = color_q[15:8];
          end else if (state_q == StFHi) begin
            state_d = StFLo;
            data_d  = color_q[7:0];
          end else begin
            if (count_q != '0) begin
              count_d = count_q - PIX_W'(1);
            end
            state_d = (count_q <= PIX_W'(1)) ? StFEnd : StFHi;
            data_d  = color_q[15:8];
          end
        end
      end
      StFEnd: begin
        fill_done_out = 1'b1;
        pending_d     = 1'b0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_ack_out   = ack_q;
  assign fill_busy_out = pending_q;
  assign byte_data_out = data_q;
  assign byte_dc_out   = dc_q;

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Randomized bench for lcd_spi_sequencer: a behavioural SPI engine records every issued byte,
// and a byte-stream reference model built from the fill/CPU rules gives the expected order.
module tb_lcd_spi_sequencer;
  localparam int unsigned PIX_W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             cpu_req_in, cpu_dc_in, cpu_ack_out;
  logic [7:0]       cpu_data_in;
  logic             fill_start_in, fill_busy_out, fill_done_out;
  logic [15:0]      fill_color_in;
  logic [PIX_W-1:0] fill_count_in;
  logic             byte_start_out, byte_dc_out, byte_busy_in, byte_done_in;
  logic [7:0]       byte_data_out;

  lcd_spi_sequencer #(.PIX_W(PIX_W), .RAMWR_CMD(8'h2C)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req_in    (cpu_req_in),
    .cpu_dc_in     (cpu_dc_in),
    .cpu_data_in   (cpu_data_in),
    .cpu_ack_out   (cpu_ack_out),
    .fill_start_in (fill_start_in),
    .fill_color_in (fill_color_in),
    .fill_count_in (fill_count_in),
    .fill_busy_out (fill_busy_out),
    .fill_done_out (fill_done_out),
    .byte_start_out(byte_start_out),
    .byte_data_out (byte_data_out),
    .byte_dc_out   (byte_dc_out),
    .byte_busy_in  (byte_busy_in),
    .byte_done_in  (byte_done_in)
  );

  int checks = 0, passes = 0;
  int ack_cnt = 0, done_cnt = 0, start_cnt = 0, viol_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int  eng_lat;
  bit  eng_abort;

  // Engine model: accepts a start, stays busy a random time, then pulses done.
  initial begin
    byte_busy_in = 1'b0;
    byte_done_in = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && byte_start_out) begin
        obs_q.push_back({byte_dc_out, byte_data_out});
        start_cnt++;
        @(posedge clk); #1;
        byte_busy_in = 1'b1;
        eng_lat   = $urandom_range(1, 5);
        eng_abort = 1'b0;
        for (int i = 0; i < eng_lat && !eng_abort; i++) begin
          @(posedge clk); #1;
          if (!reset_n) eng_abort = 1'b1;
        end
        if (!eng_abort) begin
          byte_done_in = 1'b1;
          byte_busy_in = 1'b0;
          @(posedge clk); #1;
          byte_done_in = 1'b0;
        end else begin
          byte_busy_in = 1'b0;
        end
      end
    end
  end

  // Pulse counters and protocol watch: no start while busy, byte held while busy.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (cpu_ack_out) ack_cnt++;
        if (fill_done_out) done_cnt++;
        if (byte_start_out && byte_busy_in) viol_cnt++;
        if (byte_busy_in && obs_q.size() > 0 && {byte_dc_out, byte_data_out} !== obs_q[$])
          viol_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_cpu(input logic dc, input logic [7:0] d);
    exp_q.push_back({dc, d});
  endfunction

  function automatic void model_fill(input logic [15:0] c, input int n);
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, c[15:8]});
      exp_q.push_back({1'b1, c[7:0]});
    end
  endfunction

  // Index of first differing byte between observed and expected streams, -1 if identical.
  function automatic int stream_diff();
    int n;
    n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (exp_q.size() != obs_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_streams();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic cpu_write(input logic dc, input logic [7:0] d, output bit ok);
    @(posedge clk); #1;
    cpu_req_in = 1'b1; cpu_dc_in = dc; cpu_data_in = d;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ack_out) ok = 1'b1;
    end
    @(posedge clk); #1;
    cpu_req_in = 1'b0;
  endtask

  task automatic fill_go(input logic [15:0] c, input int n);
    @(posedge clk); #1;
    fill_start_in = 1'b1; fill_color_in = c; fill_count_in = PIX_W'(n);
    @(posedge clk); #1;
    fill_start_in = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (fill_done_out) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_start_out, byte_dc_out, byte_data_out} !== 10'd0)
      $display("FAIL reset_byte_if: got %b/%b/%h want 0/0/00", byte_start_out, byte_dc_out,
               byte_data_out);
    else passes++;
    checks++;
    if ({cpu_ack_out, fill_busy_out, fill_done_out} !== 3'b000)
      $display("FAIL reset_flags: got ack/busy/done %b want 000",
               {cpu_ack_out, fill_busy_out, fill_done_out});
    else passes++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_single();
    int base_ack, d;
    bit ok;
    clear_streams();
    base_ack = ack_cnt;
    model_cpu(1'b0, 8'h11);
    @(posedge clk); #1;
    cpu_req_in = 1'b1; cpu_dc_in = 1'b0; cpu_data_in = 8'h11;
    @(negedge clk);
    checks++;
    if (byte_start_out !== 1'b0) $display("FAIL cpu_early_start: got %b want 0", byte_start_out);
    else passes++;
    @(negedge clk);
    checks++;
    if ({byte_start_out, byte_dc_out, byte_data_out} !== {1'b1, 1'b0, 8'h11})
      $display("FAIL cpu_latency: got start/dc/data %b/%b/%h want 1/0/11", byte_start_out,
               byte_dc_out, byte_data_out);
    else passes++;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ack_out) ok = 1'b1;
    end
    @(posedge clk); #1;
    cpu_req_in = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_cnt - base_ack !== 1) $display("FAIL cpu_ack_pulses: got %0d want 1", ack_cnt - base_ack);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL cpu_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_fill();
    int base_done, n, d;
    logic [15:0] c;
    bit ok;
    clear_streams();
    base_done = done_cnt;
    for (int k = 0; k < 5; k++) begin
      c = (k == 0) ? 16'hF800 : 16'($urandom);
      n = (k == 0) ? 2 : int'($urandom_range(0, 3));
      model_fill(c, n);
      fill_go(c, n);
      wait_done(ok);
      checks++;
      if (!ok) $display("FAIL fill_done_seen[%0d]: got no done want done", k);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (fill_busy_out !== 1'b0) $display("FAIL fill_busy_after[%0d]: got %b want 0", k,
                                           fill_busy_out);
      else passes++;
    end
    checks++;
    if (done_cnt - base_done !== 5) $display("FAIL fill_done_count: got %0d want 5",
                                             done_cnt - base_done);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL fill_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_simultaneous();
    int base_done, base_ack, n, d;
    logic [15:0] c;
    logic [7:0] cd;
    logic cdc;
    bit ok_c, ok_f, busy_bad;
    clear_streams();
    base_done = done_cnt; base_ack = ack_cnt;
    c = 16'($urandom); n = int'($urandom_range(1, 3));
    cd = 8'($urandom); cdc = 1'($urandom);
    model_cpu(cdc, cd);
    model_fill(c, n);
    busy_bad = 1'b0; ok_f = 1'b0;
    fork
      cpu_write(cdc, cd, ok_c);
      begin
        fill_go(c, n);
        for (int i = 0; i < 3000 && !ok_f; i++) begin
          @(negedge clk);
          if (fill_busy_out !== 1'b1) busy_bad = 1'b1;
          if (fill_done_out) ok_f = 1'b1;
        end
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if ({ok_c, ok_f} !== 2'b11) $display("FAIL sim_completion: got ack/done %b want 11", {ok_c, ok_f});
    else passes++;
    checks++;
    if (busy_bad !== 1'b0) $display("FAIL sim_busy_held: got drop=%b want 0", busy_bad);
    else passes++;
    checks++;
    if ({done_cnt - base_done, ack_cnt - base_ack} !== {32'd1, 32'd1})
      $display("FAIL sim_pulses: got done %0d ack %0d want 1 1", done_cnt - base_done,
               ack_cnt - base_ack);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL sim_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_cpu_mid_fill();
    int base_start, base_done, n, d;
    int done_at_ack;
    logic [15:0] c;
    logic [7:0] cd;
    bit ok_f, ok_c, reached;
    clear_streams();
    base_start = start_cnt; base_done = done_cnt;
    c = 16'($urandom); n = int'($urandom_range(1, 3)); cd = 8'($urandom);
    model_fill(c, n);
    model_cpu(1'b1, cd);
    reached = 1'b0; ok_c = 1'b0; done_at_ack = 0;
    fork
      begin
        fill_go(c, n);
        wait_done(ok_f);
      end
      begin
        for (int i = 0; i < 3000 && !reached; i++) begin
          @(negedge clk);
          if (start_cnt - base_start >= 3) reached = 1'b1;
        end
        if (reached) begin
          cpu_write(1'b1, cd, ok_c);
          done_at_ack = done_cnt - base_done;
        end
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if ({reached, ok_f, ok_c} !== 3'b111)
      $display("FAIL mid_completion: got reach/done/ack %b want 111", {reached, ok_f, ok_c});
    else passes++;
    checks++;
    if (done_at_ack !== 1) $display("FAIL mid_order: fill dones before ack got %0d want 1",
                                    done_at_ack);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL mid_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_zero_count();
    int base_start, base_done, d;
    bit ok;
    clear_streams();
    base_start = start_cnt; base_done = done_cnt;
    model_fill(16'($urandom), 0);
    fork
      fill_go(exp_q[0] == 9'h02C ? 16'h1234 : 16'h0000, 0);
      begin
        repeat (2) @(posedge clk);
        fill_go(16'hFFFF, 5);
      end
    join
    wait_done(ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok) $display("FAIL zero_done_seen: got no done want done");
    else passes++;
    checks++;
    if ({start_cnt - base_start, done_cnt - base_done} !== {32'd1, 32'd1})
      $display("FAIL zero_counts: got bytes %0d dones %0d want 1 1", start_cnt - base_start,
               done_cnt - base_done);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL zero_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int base_done, base_ack, nf, nc, n, d;
    logic [15:0] c;
    logic [7:0] cd;
    logic cdc;
    bit ok, all_ok;
    clear_streams();
    base_done = done_cnt; base_ack = ack_cnt;
    nf = 0; nc = 0; all_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        cd = 8'($urandom); cdc = 1'($urandom);
        model_cpu(cdc, cd);
        cpu_write(cdc, cd, ok);
        nc++;
      end else begin
        c = 16'($urandom); n = int'($urandom_range(0, 3));
        model_fill(c, n);
        fill_go(c, n);
        wait_done(ok);
        nf++;
      end
      if (!ok) all_ok = 1'b0;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (!all_ok) $display("FAIL b2b_completion: got a timeout want none");
    else passes++;
    checks++;
    if ({done_cnt - base_done, ack_cnt - base_ack} !== {nf, nc})
      $display("FAIL b2b_pulses: got done %0d ack %0d want %0d %0d", done_cnt - base_done,
               ack_cnt - base_ack, nf, nc);
    else passes++;
    d = stream_diff();
    checks++;
    if (d != -1) $display("FAIL b2b_stream: first diff at %0d (obs %0d bytes) want %0d bytes equal",
                          d, obs_q.size(), exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    int base_start, base_ack, base_done;
    bit reached;
    clear_streams();
    base_start = start_cnt;
    reached = 1'b0;
    fill_go(16'($urandom) | 16'h0101, 2);
    for (int i = 0; i < 3000 && !reached; i++) begin
      @(negedge clk);
      if (start_cnt - base_start >= 3) reached = 1'b1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!reached) $display("FAIL rst_reach_lo: got no third byte want third byte");
    else passes++;
    checks++;
    if ({byte_start_out, byte_dc_out, byte_data_out, cpu_ack_out, fill_busy_out, fill_done_out}
        !== 13'd0)
      $display("FAIL rst_outputs: got start/dc/data/ack/busy/done %b/%b/%h/%b/%b/%b want all 0",
               byte_start_out, byte_dc_out, byte_data_out, cpu_ack_out, fill_busy_out,
               fill_done_out);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    base_start = start_cnt; base_ack = ack_cnt; base_done = done_cnt;
    repeat (25) @(negedge clk);
    checks++;
    if ({start_cnt - base_start, ack_cnt - base_ack, done_cnt - base_done, 31'(fill_busy_out)}
        !== 127'd0)
      $display("FAIL rst_quiet: got starts %0d acks %0d dones %0d busy %b want 0 0 0 0",
               start_cnt - base_start, ack_cnt - base_ack, done_cnt - base_done, fill_busy_out);
    else passes++;
  endtask

  task automatic test_protocol();
    checks++;
    if (viol_cnt !== 0) $display("FAIL engine_protocol: got %0d violations want 0", viol_cnt);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req_in = 1'b0; cpu_dc_in = 1'b0; cpu_data_in = '0;
    fill_start_in = 1'b0; fill_color_in = '0; fill_count_in = '0;
    test_reset();
    test_cpu_single();
    test_fill();
    test_simultaneous();
    test_cpu_mid_fill();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
